// File: rtl/imuldiv_int_mul_iter_param.sv
// imuldiv_int_mul_iter_param: iterative W x W -> 2W multiplier retiring K multiplier bits per cycle.
// Define IMULDIV_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module imuldiv_int_mul_iter_param #(
  parameter int W = 32,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic           mulreq_msg_signed,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy
);
  localparam int N  = W / K;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(K == 1 || K == 2 || K == 4 || K == 8) || (W % K) != 0) begin : g_bad_cfg
    $error("imuldiv_int_mul_iter_param: K must be 1,2,4,8 and divide W");
  end

  logic [1:0]    state_q, state_d;
  logic [2*W-1:0] a_q, a_d, acc_q, acc_d, result_q, result_d;
  logic [W-1:0]  b_q, b_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]   a_mag, b_mag, b_shift;
  logic [2*W-1:0] pp, sum;
  logic           last;

  // The most negative value negates to itself, which read unsigned is its exact magnitude.
  assign a_mag   = (mulreq_msg_signed && mulreq_msg_a[W-1]) ? -mulreq_msg_a : mulreq_msg_a;
  assign b_mag   = (mulreq_msg_signed && mulreq_msg_b[W-1]) ? -mulreq_msg_b : mulreq_msg_b;
  assign pp      = a_q * {{(2*W-K){1'b0}}, b_q[K-1:0]};
  assign sum     = acc_q + pp;
  assign b_shift = b_q >> K;
`ifdef IMULDIV_MUL_EARLY_TERM_EN
  assign last    = (cnt_q == CW'(N - 1)) || (b_shift == '0);
`else
  assign last    = cnt_q == CW'(N - 1);
`endif

  assign mulreq_rdy         = state_q == IDLE;
  assign mulresp_val        = state_q == DONE;
  assign mulresp_msg_result = result_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == IDLE && mulreq_val) begin
      a_d     = {{W{1'b0}}, a_mag};
      b_d     = b_mag;
      neg_d   = mulreq_msg_signed && (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
      acc_d   = '0;
      cnt_d   = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      acc_d = sum;
      a_d   = a_q << K;
      b_d   = b_shift;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        result_d = neg_q ? -sum : sum;
        state_d  = DONE;
      end
    end else if (state_q == DONE && mulresp_rdy) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_imuldiv_int_mul_iter_param.sv
// tb_imuldiv_int_mul_iter_param: vector table, random ops against an arithmetic model, and handshake/reset corners.
module tb_imuldiv_int_mul_iter_param;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] a = 0, b = 0, a4 = 0, b4 = 0;
  logic        s = 0, val = 0, rrdy = 0, s4 = 0, val4 = 0, rrdy4 = 0;
  logic        rdy, rval, rdy4, rval4;
  logic [63:0] res, res4;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  imuldiv_int_mul_iter_param #(.W(32), .K(1)) u_dut (
    .clk(clk), .reset(reset), .mulreq_msg_a(a), .mulreq_msg_b(b), .mulreq_msg_signed(s),
    .mulreq_val(val), .mulreq_rdy(rdy), .mulresp_msg_result(res), .mulresp_val(rval), .mulresp_rdy(rrdy));

  imuldiv_int_mul_iter_param #(.W(32), .K(4)) u_dut4 (
    .clk(clk), .reset(reset), .mulreq_msg_a(a4), .mulreq_msg_b(b4), .mulreq_msg_signed(s4),
    .mulreq_val(val4), .mulreq_rdy(rdy4), .mulresp_msg_result(res4), .mulresp_val(rval4), .mulresp_rdy(rrdy4));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sg);
    longint p;
    if (sg) p = longint'($signed(x)) * longint'($signed(y));
    else p = longint'({32'b0, x}) * longint'({32'b0, y});
    return 64'(p);
  endfunction

  function automatic int lat_model(input logic [31:0] y, input logic sg, input int k);
    logic [31:0] m;
    int bits;
    m = (sg && y[31]) ? -y : y;
    bits = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
`ifdef IMULDIV_MUL_EARLY_TERM_EN
    return (bits == 0) ? 1 : (bits + k - 1) / k;
`else
    return 32 / k;
`endif
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sg);
    check("req_rdy_before_issue", 64'(rdy), 64'd1);
    a = x; b = y; s = sg; val = 1;
    @(posedge clk); #1;
    val = 0;
    a = $urandom; b = $urandom; s = ~sg;
  endtask

  task automatic wait_val(output int lat);
    lat = 0;
    while (!rval && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    rrdy = 1;
    @(posedge clk); #1;
    rrdy = 0;
    check("val_low_after_take", 64'(rval), 64'd0);
    check("rdy_high_after_take", 64'(rdy), 64'd1);
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic sg, input logic [63:0] exp);
    int lat;
    issue(x, y, sg);
    wait_val(lat);
    check("latency", 64'(lat), 64'(lat_model(y, sg, 1)));
    check("result", res, exp);
    take();
  endtask

  initial begin
    vec_t vt[8];
    int lat;
    logic [63:0] held;
    logic ok;
    vt[0] = '{32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vt[4] = '{32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000};
    vt[5] = '{32'h12345678, 32'd0, 1'b1, 64'd0};
    vt[6] = '{32'h12345678, 32'd9, 1'b0, 64'h00000000_A3D70A38};
    vt[7] = '{32'd5, 32'h80000000, 1'b0, 64'h00000002_80000000};

    #12;
    check("reset_rdy", 64'(rdy), 64'd1);
    check("reset_val", 64'(rval), 64'd0);
    check("reset_result", res, 64'd0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run(vt[i].a, vt[i].b, vt[i].s, vt[i].exp);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] x, y;
      logic sg;
      x = $urandom; y = (i % 4 == 0) ? ($urandom & 32'hFF) : $urandom; sg = 1'($urandom);
      run(x, y, sg, model(x, y, sg));
    end

    // Backpressure in DONE with a stray request.
    issue(32'd3, 32'd5, 1'b0);
    wait_val(lat);
    check("bp_result", res, 64'd15);
    ok = 1;
    held = res;
    for (int i = 0; i < 10; i++) begin
      a = 32'd100; b = 32'd100; val = (i % 3 == 0);
      @(posedge clk); #1;
      if (!rval || rdy || res !== held) ok = 0;
    end
    val = 0;
    check("bp_hold", 64'(ok), 64'd1);
    take();
    @(posedge clk); #1;
    check("bp_no_queued_req", 64'(rdy), 64'd1);
    check("bp_result_held_idle", res, 64'd15);

    // Reset in the middle of CALC.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    #1;
    check("midreset_rdy", 64'(rdy), 64'd1);
    check("midreset_val", 64'(rval), 64'd0);
    check("midreset_result", res, 64'd0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    run(32'd6, 32'd7, 1'b1, 64'd42);

    // K=4 instance.
    a4 = 32'h12345678; b4 = 32'd9; s4 = 0; val4 = 1;
    @(posedge clk); #1;
    val4 = 0;
    lat = 0;
    while (!rval4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("k4_latency", 64'(lat), 64'(lat_model(32'd9, 1'b0, 4)));
    check("k4_result", res4, 64'h00000000_A3D70A38);
    rrdy4 = 1;
    @(posedge clk); #1;
    rrdy4 = 0;
    check("k4_rdy_after_take", 64'(rdy4), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
